// File: rtl/ee_rd_arbiter.sv
// Two-port arbiter and read sequencer for the shared EEPROM e2l read port.
// Optional round-robin arbitration is enabled by defining EE_ARB_RR_EN.
module ee_rd_arbiter #(
  parameter int unsigned RD_CYC = 16
) (
  input  logic        timer_clk,
  input  logic        por_rst_n,
  input  logic        por_cfg_done,
  input  logic        req0,
  input  logic [15:0] addr0,
  input  logic        req1,
  input  logic [15:0] addr1,
  input  logic [31:0] ee_data_e2l,
  output logic        ee_vs_en,
  output logic        ee_rd_en,
  output logic [15:0] ee_addr,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [1:0]  gnt,
  output logic        busy
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (RD_CYC > 1) ? $clog2(RD_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    HOLD,
    DONE
  } state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [1:0]          gnt_d;
  logic                vs_d, rd_d, ack0_d, ack1_d;
  logic                elig0, elig1, win1;

  assign elig0 = req0;
  assign elig1 = req1 & por_cfg_done;

`ifdef EE_ARB_RR_EN
  // last1: port 1 owned the most recent grant; on a tie the other port wins
  logic last1, last1_d;
  assign win1 = elig1 & (~elig0 | ~last1);
`else
  assign win1 = elig1 & ~elig0;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    addr_d  = ee_addr;
    rdata_d = rdata;
    gnt_d   = gnt;
    vs_d    = ee_vs_en;
    rd_d    = ee_rd_en;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef EE_ARB_RR_EN
    last1_d = last1;
`endif
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          gnt_d   = win1 ? 2'b10 : 2'b01;
          addr_d  = win1 ? addr1 : addr0;
          vs_d    = 1'b1;
          state_d = SETUP;
`ifdef EE_ARB_RR_EN
          last1_d = win1;
`endif
        end else begin
          gnt_d = 2'b00;
          vs_d  = 1'b0;
        end
      end
      SETUP: begin
        rd_d    = 1'b1;
        cnt_d   = '0;
        state_d = READ;
      end
      READ: begin
        if (cnt == CNT_W'(RD_CYC - 1)) begin
          rd_d    = 1'b0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      HOLD: state_d = DONE;
      DONE: begin
        rdata_d = ee_data_e2l;
        ack0_d  = gnt[0];
        ack1_d  = gnt[1];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge timer_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ee_addr  <= '0;
      rdata    <= '0;
      gnt      <= 2'b00;
      ee_vs_en <= 1'b0;
      ee_rd_en <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      busy     <= 1'b0;
`ifdef EE_ARB_RR_EN
      last1    <= 1'b1;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      ee_addr  <= addr_d;
      rdata    <= rdata_d;
      gnt      <= gnt_d;
      ee_vs_en <= vs_d;
      ee_rd_en <= rd_d;
      ack0     <= ack0_d;
      ack1     <= ack1_d;
      busy     <= (state_d != IDLE);
`ifdef EE_ARB_RR_EN
      last1    <= last1_d;
`endif
    end
  end

endmodule

// File: tb/tb_ee_rd_arbiter.sv
// Self-checking bench for ee_rd_arbiter: directed scenarios plus random traffic
// against a transaction-schedule reference model.
module tb_ee_rd_arbiter;

  parameter int unsigned RD_CYC = 16;
  localparam int RC = int'(RD_CYC);

  logic        timer_clk = 1'b0;
  logic        por_rst_n = 1'b1;
  logic        por_cfg_done = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0;
  logic [31:0] ee_data_e2l = '0;
  logic        ee_vs_en, ee_rd_en, ack0, ack1, busy;
  logic [15:0] ee_addr;
  logic [31:0] rdata;
  logic [1:0]  gnt;

  ee_rd_arbiter #(.RD_CYC(RD_CYC)) dut (
    .timer_clk(timer_clk), .por_rst_n(por_rst_n), .por_cfg_done(por_cfg_done),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .ee_data_e2l(ee_data_e2l), .ee_vs_en(ee_vs_en), .ee_rd_en(ee_rd_en),
    .ee_addr(ee_addr), .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt), .busy(busy)
  );

  always #5 timer_clk = ~timer_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a read accepted at edge n=start is a fixed schedule of
  // cycles relative to start; the port is free again at start+RC+4.
  int          n = 0;
  int          start = 0;
  bit          active = 0;
  logic [1:0]  m_gnt = '0;
  logic [15:0] m_addr = '0;
  logic [31:0] m_rdata = '0;
  bit          m_vs = 0;
  bit          m_ack0 = 0, m_ack1 = 0;
`ifdef EE_ARB_RR_EN
  bit          m_last1 = 1;
`endif

  task automatic model_reset();
    active = 0; m_gnt = '0; m_addr = '0; m_rdata = '0; m_vs = 0;
    m_ack0 = 0; m_ack1 = 0;
`ifdef EE_ARB_RR_EN
    m_last1 = 1;
`endif
  endtask

  task automatic model_edge();
    bit e0, e1, w1;
    if (active && (n - start) == RC + 3) m_rdata = ee_data_e2l;
    if (active && (n - start) >= RC + 4) active = 0;
    if (!active) begin
      e0 = req0;
      e1 = req1 && por_cfg_done;
      if (e0 || e1) begin
`ifdef EE_ARB_RR_EN
        w1 = e1 && (!e0 || !m_last1);
        m_last1 = w1;
`else
        w1 = !e0;
`endif
        active = 1;
        start  = n;
        m_gnt  = w1 ? 2'b10 : 2'b01;
        m_addr = w1 ? addr1 : addr0;
        m_vs   = 1;
      end else begin
        m_vs  = 0;
        m_gnt = 2'b00;
      end
    end
  endtask

  task automatic compare();
    int p;
    bit e_rd, e_busy;
    p      = n - start;
    e_rd   = active && p >= 1 && p <= RC;
    e_busy = active && p <= RC + 2;
    m_ack0 = active && p == RC + 3 && m_gnt[0];
    m_ack1 = active && p == RC + 3 && m_gnt[1];
    check("ee_vs_en", 32'(ee_vs_en), 32'(m_vs));
    check("ee_rd_en", 32'(ee_rd_en), 32'(e_rd));
    check("ee_addr",  32'(ee_addr),  32'(m_addr));
    check("gnt",      32'(gnt),      32'(m_gnt));
    check("ack0",     32'(ack0),     32'(m_ack0));
    check("ack1",     32'(ack1),     32'(m_ack1));
    check("busy",     32'(busy),     32'(e_busy));
    check("rdata",    rdata,         m_rdata);
  endtask

  task automatic tick();
    @(posedge timer_clk);
    n++;
    model_edge();
    @(negedge timer_clk);
    compare();
  endtask

  initial begin
    int rd_cnt, ack_at, ack_cnt, seen;
    bit prev_busy, hold0, hold1;
    bit gq[$];
    int exp_seq[4];
`ifdef EE_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif

    // Reset values
    #1 por_rst_n = 1'b0;
    #1;
    check("rst_vs_en", 32'(ee_vs_en), 32'(0));
    check("rst_rd_en", 32'(ee_rd_en), 32'(0));
    check("rst_addr",  32'(ee_addr),  32'(0));
    check("rst_ack0",  32'(ack0),     32'(0));
    check("rst_ack1",  32'(ack1),     32'(0));
    check("rst_rdata", rdata,         32'h0);
    check("rst_gnt",   32'(gnt),      32'(0));
    check("rst_busy",  32'(busy),     32'(0));
    model_reset();
    @(negedge timer_clk);
    @(negedge timer_clk);
    por_rst_n = 1'b1;
    tick();

    // Single POR read
    addr0 = 16'hFFF4; ee_data_e2l = 32'h3111_1511; req0 = 1'b1;
    rd_cnt = 0; ack_at = 0; ack_cnt = 0;
    for (int i = 1; i <= RC + 6; i++) begin
      tick();
      if (i == 1) check("vs_rise", 32'(ee_vs_en), 32'(1));
      if (ee_rd_en) rd_cnt++;
      if (ack0) ack_at = i;
      if (ack1) ack_cnt++;
      if (m_ack0) req0 = 1'b0;
    end
    check("rd_en_len", 32'(rd_cnt), 32'(RC));
    check("ack0_lat", 32'(ack_at), 32'(RC + 4));
    check("rdata_t1", rdata, 32'h3111_1511);
    check("ack1_quiet", 32'(ack_cnt), 32'(0));

    // Host port gated until configuration done
    req1 = 1'b1; addr1 = 16'($urandom); ee_data_e2l = $urandom;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (busy || gnt != 2'b00) seen++;
    end
    check("gated_idle", 32'(seen), 32'(0));
    por_cfg_done = 1'b1;
    ack_at = 0;
    for (int i = 1; i <= RC + 6; i++) begin
      tick();
      if (ack1) ack_at = i;
      if (m_ack1) req1 = 1'b0;
    end
    check("ack1_lat", 32'(ack_at), 32'(RC + 4));

    // Simultaneous held requests: grant order
    req0 = 1'b1; req1 = 1'b1; addr0 = 16'($urandom); addr1 = 16'($urandom);
    prev_busy = 0;
    for (int i = 0; i < 4 * (RC + 4); i++) begin
      tick();
      if (busy && !prev_busy) gq.push_back(gnt == 2'b10);
      prev_busy = busy;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < RC + 6; i++) tick();
    check("grant_count", 32'(gq.size()), 32'(4));
    for (int i = 0; i < 4 && i < gq.size(); i++)
      check($sformatf("grant_seq%0d", i), 32'(gq[i]), 32'(exp_seq[i]));

    // Host request dropped mid-transaction
    req1 = 1'b1; addr1 = 16'($urandom);
    ack_cnt = 0;
    for (int i = 0; i < 3; i++) tick();
    req1 = 1'b0;
    for (int i = 0; i < RC + 6; i++) begin
      tick();
      if (ack1) ack_cnt++;
    end
    check("drop_ack1", 32'(ack_cnt), 32'(1));

    // Asynchronous reset during READ
    req0 = 1'b1; addr0 = 16'($urandom);
    for (int i = 0; i < 3; i++) tick();
    #2 por_rst_n = 1'b0;
    #1;
    check("arst_rd_en", 32'(ee_rd_en), 32'(0));
    check("arst_vs_en", 32'(ee_vs_en), 32'(0));
    check("arst_gnt",   32'(gnt),      32'(0));
    check("arst_busy",  32'(busy),     32'(0));
    req0 = 1'b0;
    model_reset();
    @(negedge timer_clk);
    @(negedge timer_clk);
    por_rst_n = 1'b1;
    ack_cnt = 0;
    for (int i = 0; i < RC + 6; i++) begin
      tick();
      if (ack0) ack_cnt++;
    end
    check("arst_no_ack", 32'(ack_cnt), 32'(0));
    req0 = 1'b1; addr0 = 16'($urandom); ee_data_e2l = $urandom;
    ack_cnt = 0;
    for (int i = 0; i < RC + 6; i++) begin
      tick();
      if (ack0) ack_cnt++;
      if (m_ack0) req0 = 1'b0;
    end
    check("post_rst_ack", 32'(ack_cnt), 32'(1));

    // Random traffic
    hold0 = 0; hold1 = 0;
    for (int i = 0; i < 2500; i++) begin
      ee_data_e2l = $urandom;
      if (!req0 && $urandom_range(7) == 0) begin
        req0 = 1'b1; addr0 = 16'($urandom); hold0 = ($urandom_range(3) == 0);
      end
      if (!req1 && $urandom_range(5) == 0) begin
        req1 = 1'b1; addr1 = 16'($urandom); hold1 = ($urandom_range(3) == 0);
      end
      if ($urandom_range(199) == 0) por_cfg_done = ~por_cfg_done;
      tick();
      if ((m_ack0 && !hold0) || $urandom_range(99) == 0) req0 = 1'b0;
      if ((m_ack1 && !hold1) || $urandom_range(99) == 0) req1 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
